// File: rtl/md_unit.sv
// md_unit: E-stage multiply/divide unit with architectural HI/LO registers.
// MULT/MULTU/DIV/DIVU compute their result at the start edge, hold it as pending,
// and commit it to HI/LO after a fixed number of busy cycles. MTHI/MTLO write
// directly. rd_data only ever shows committed HI/LO.
module md_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        md_valid,
    input  logic [2:0]  md_op,
    input  logic [31:0] rs_data,
    input  logic [31:0] rt_data,
    input  logic        hilo_sel,
    output logic        busy,
    output logic        start,
    output logic        md_stall,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic [31:0] rd_data
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    localparam logic [2:0] OP_MULT  = 3'b001;
    localparam logic [2:0] OP_MULTU = 3'b010;
    localparam logic [2:0] OP_DIV   = 3'b011;
    localparam logic [2:0] OP_DIVU  = 3'b100;
    localparam logic [2:0] OP_MTHI  = 3'b101;
    localparam logic [2:0] OP_MTLO  = 3'b110;

    typedef enum logic {
        S_IDLE,
        S_BUSY
    } state_t;

    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [31:0]        r_pend_hi;
    logic [31:0]        r_pend_lo;
    logic               r_pend_ok;
    logic [31:0]        r_hi;
    logic [31:0]        r_lo;

    logic               w_start;
    logic               w_is_div;
    logic               w_div_zero;
    logic signed [63:0] w_smul;
    logic [63:0]        w_umul;
    logic [31:0]        w_abs_a;
    logic [31:0]        w_abs_b;
    logic [31:0]        w_abs_b_safe;
    logic [31:0]        w_rt_safe;
    logic [31:0]        w_sq_mag;
    logic [31:0]        w_sr_mag;
    logic [31:0]        w_res_hi;
    logic [31:0]        w_res_lo;

    assign busy     = (r_state == S_BUSY);
    assign w_start  = md_valid && !busy && (md_op >= OP_MULT) && (md_op <= OP_DIVU);
    assign start    = w_start;
    assign md_stall = busy | w_start;
    assign hi       = r_hi;
    assign lo       = r_lo;
    assign rd_data  = hilo_sel ? r_hi : r_lo;

    assign w_is_div   = (md_op == OP_DIV) || (md_op == OP_DIVU);
    assign w_div_zero = (rt_data == 32'd0);

    // Products: sign-extend for MULT, zero-extend for MULTU.
    assign w_smul = $signed({{32{rs_data[31]}}, rs_data}) * $signed({{32{rt_data[31]}}, rt_data});
    assign w_umul = {32'd0, rs_data} * {32'd0, rt_data};

    // Signed divide runs on magnitudes; 0x80000000 keeps its magnitude as unsigned 2^31.
    // The divisor is forced to 1 on divide-by-zero so the divider never sees 0;
    // that result is discarded anyway.
    assign w_abs_a      = rs_data[31] ? (32'd0 - rs_data) : rs_data;
    assign w_abs_b      = rt_data[31] ? (32'd0 - rt_data) : rt_data;
    assign w_abs_b_safe = w_div_zero ? 32'd1 : w_abs_b;
    assign w_rt_safe    = w_div_zero ? 32'd1 : rt_data;
    assign w_sq_mag     = w_abs_a / w_abs_b_safe;
    assign w_sr_mag     = w_abs_a % w_abs_b_safe;

    // Select the 64-bit result that will be held pending for the started op.
    always_comb begin
        // NOTE: default every output first so no path through the case infers a latch.
        w_res_hi = 32'd0;
        w_res_lo = 32'd0;
        case (md_op)
            OP_MULT: begin
                w_res_hi = w_smul[63:32];
                w_res_lo = w_smul[31:0];
            end
            OP_MULTU: begin
                w_res_hi = w_umul[63:32];
                w_res_lo = w_umul[31:0];
            end
            OP_DIV: begin
                w_res_lo = (rs_data[31] ^ rt_data[31]) ? (32'd0 - w_sq_mag) : w_sq_mag;
                w_res_hi = rs_data[31] ? (32'd0 - w_sr_mag) : w_sr_mag;
            end
            OP_DIVU: begin
                w_res_lo = rs_data / w_rt_safe;
                w_res_hi = rs_data % w_rt_safe;
            end
            default: ;
        endcase
    end

    // IDLE/BUSY control, pending result, busy counter and committed HI/LO.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            // NOTE: sequential state uses non-blocking assignments so every register
            // samples pre-edge values regardless of statement order.
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_pend_hi <= '0;
            r_pend_lo <= '0;
            r_pend_ok <= 1'b0;
            r_hi      <= '0;
            r_lo      <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_start) begin
                        r_state   <= S_BUSY;
                        r_cnt     <= w_is_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
                        r_pend_hi <= w_res_hi;
                        r_pend_lo <= w_res_lo;
                        r_pend_ok <= !(w_is_div && w_div_zero);
                    end else if (md_valid && (md_op == OP_MTHI)) begin
                        r_hi <= rs_data;
                    end else if (md_valid && (md_op == OP_MTLO)) begin
                        r_lo <= rs_data;
                    end
                end
                S_BUSY: begin
                    if (r_cnt == CNT_W'(1)) begin
                        r_state <= S_IDLE;
                        r_cnt   <= '0;
                        if (r_pend_ok) begin
                            r_hi <= r_pend_hi;
                            r_lo <= r_pend_lo;
                        end
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_md_unit.sv
// tb_md_unit: self-checking bench for md_unit. Expected HI/LO and busy length are
// computed by a reference model when an op is issued, queued, and compared when
// the DUT drops busy.
module tb_md_unit;

    localparam int MULT_CYCLES = 5;
    localparam int DIV_CYCLES  = 10;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          cycles;
    } exp_t;

    logic        clk;
    logic        reset;
    logic        md_valid;
    logic [2:0]  md_op;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic        hilo_sel;
    logic        busy;
    logic        start;
    logic        md_stall;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] rd_data;

    int   n_checks;
    int   n_fails;
    exp_t sb_q[$];

    md_unit #(
        .MULT_CYCLES(MULT_CYCLES),
        .DIV_CYCLES (DIV_CYCLES)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .md_valid(md_valid),
        .md_op   (md_op),
        .rs_data (rs_data),
        .rt_data (rt_data),
        .hilo_sel(hilo_sel),
        .busy    (busy),
        .start   (start),
        .md_stall(md_stall),
        .hi      (hi),
        .lo      (lo),
        .rd_data (rd_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model using 64-bit arithmetic; returns the HI/LO after the op.
    function automatic exp_t model(input logic [2:0] op, input logic [31:0] a,
                                   input logic [31:0] b, input logic [31:0] old_hi,
                                   input logic [31:0] old_lo);
        exp_t               e;
        logic signed [63:0] sa;
        logic signed [63:0] sb;
        logic signed [63:0] sp;
        logic signed [63:0] sq;
        logic signed [63:0] sr;
        logic [63:0]        up;
        sa = $signed({{32{a[31]}}, a});
        sb = $signed({{32{b[31]}}, b});
        e.hi = old_hi;
        e.lo = old_lo;
        e.cycles = (op == 3'b011 || op == 3'b100) ? DIV_CYCLES : MULT_CYCLES;
        case (op)
            3'b001: begin
                sp = sa * sb;
                e.hi = sp[63:32];
                e.lo = sp[31:0];
            end
            3'b010: begin
                up = {32'd0, a} * {32'd0, b};
                e.hi = up[63:32];
                e.lo = up[31:0];
            end
            3'b011: begin
                if (b != 32'd0) begin
                    sq = sa / sb;
                    sr = sa % sb;
                    e.hi = sr[31:0];
                    e.lo = sq[31:0];
                end
            end
            3'b100: begin
                if (b != 32'd0) begin
                    e.hi = a % b;
                    e.lo = a / b;
                end
            end
            default: ;
        endcase
        return e;
    endfunction

    // Issue one multi-cycle op, follow it through busy, then compare against the queue.
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input bit collide);
        exp_t        e;
        int          n;
        logic [31:0] old_hi;
        logic [31:0] old_lo;
        @(negedge clk);
        old_hi = hi;
        old_lo = lo;
        sb_q.push_back(model(op, a, b, old_hi, old_lo));
        md_valid = 1'b1;
        md_op    = op;
        rs_data  = a;
        rt_data  = b;
        #1;
        check("start_issue", {63'd0, start}, 64'd1);
        check("stall_issue", {63'd0, md_stall}, 64'd1);
        @(negedge clk);
        md_valid = 1'b0;
        md_op    = 3'b000;
        rs_data  = $urandom;
        rt_data  = $urandom;
        n = 0;
        while (busy === 1'b1 && n < 50) begin
            n++;
            check("hold_hilo", {hi, lo}, {old_hi, old_lo});
            check("stall_busy", {63'd0, md_stall}, 64'd1);
            if (collide && n == 2) begin
                md_valid = 1'b1;
                md_op    = 3'b110;
                rs_data  = 32'h0000_00AB;
            end else if (collide && n == 3) begin
                md_valid = 1'b1;
                md_op    = 3'b001;
                rs_data  = 32'h0000_0003;
            end else begin
                md_valid = 1'b0;
                md_op    = 3'b000;
            end
            #1;
            check("start_busy", {63'd0, start}, 64'd0);
            @(negedge clk);
        end
        md_valid = 1'b0;
        md_op    = 3'b000;
        e = sb_q.pop_front();
        check("busy_len", 64'(n), 64'(e.cycles));
        check("hi", {32'd0, hi}, {32'd0, e.hi});
        check("lo", {32'd0, lo}, {32'd0, e.lo});
        check("stall_done", {63'd0, md_stall}, 64'd0);
        hilo_sel = 1'b1;
        #1;
        check("rd_hi", {32'd0, rd_data}, {32'd0, e.hi});
        hilo_sel = 1'b0;
        #1;
        check("rd_lo", {32'd0, rd_data}, {32'd0, e.lo});
    endtask

    // Single-cycle MTHI/MTLO write.
    task automatic move_to(input logic [2:0] op, input logic [31:0] val);
        @(negedge clk);
        md_valid = 1'b1;
        md_op    = op;
        rs_data  = val;
        #1;
        check("start_mt", {63'd0, start}, 64'd0);
        @(negedge clk);
        md_valid = 1'b0;
        md_op    = 3'b000;
    endtask

    initial begin
        logic [2:0]  rop;
        logic [31:0] ra;
        logic [31:0] rb;
        n_checks = 0;
        n_fails  = 0;
        reset    = 1'b0;
        md_valid = 1'b0;
        md_op    = 3'b000;
        rs_data  = 32'd0;
        rt_data  = 32'd0;
        hilo_sel = 1'b0;

        repeat (3) @(negedge clk);
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_hilo", {hi, lo}, 64'd0);
        check("rst_stall", {63'd0, md_stall}, 64'd0);
        reset = 1'b1;

        // MTHI then MFHI on the next cycle.
        @(negedge clk);
        md_valid = 1'b1;
        md_op    = 3'b101;
        rs_data  = 32'h0000_1234;
        #1;
        check("mthi_nobusy", {63'd0, md_stall}, 64'd0);
        @(negedge clk);
        md_valid = 1'b0;
        md_op    = 3'b000;
        hilo_sel = 1'b1;
        #1;
        check("mfhi", {32'd0, rd_data}, 64'h1234);
        check("mthi_busy", {63'd0, busy}, 64'd0);

        // Back-to-back MTLO / MTHI, each visible one cycle later.
        @(negedge clk);
        md_valid = 1'b1;
        md_op    = 3'b110;
        rs_data  = 32'h0000_5555;
        @(negedge clk);
        check("b2b_lo", {32'd0, lo}, 64'h5555);
        md_op   = 3'b101;
        rs_data = 32'h0000_6666;
        @(negedge clk);
        check("b2b_hi", {32'd0, hi}, 64'h6666);
        md_valid = 1'b0;
        md_op    = 3'b000;

        // Ops that must have no effect.
        @(negedge clk);
        md_valid = 1'b1;
        md_op    = 3'b111;
        rs_data  = 32'hDEAD_BEEF;
        #1;
        check("op7_start", {63'd0, start}, 64'd0);
        @(negedge clk);
        md_op = 3'b000;
        @(negedge clk);
        md_valid = 1'b0;
        md_op    = 3'b001;
        rt_data  = 32'd9;
        #1;
        check("novalid_start", {63'd0, start}, 64'd0);
        @(negedge clk);
        md_op = 3'b000;
        check("noeffect", {hi, lo, 31'd0, busy}, {32'h6666, 32'h5555, 32'd0});

        // Main arithmetic.
        run_op(3'b001, 32'hFFFF_FFFE, 32'd3, 1'b0);
        check("mult_const", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFA);
        run_op(3'b010, 32'hFFFF_FFFE, 32'd3, 1'b0);
        check("multu_const", {hi, lo}, 64'h0000_0002_FFFF_FFFA);
        run_op(3'b011, 32'hFFFF_FFF9, 32'd2, 1'b0);
        check("div_const", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
        run_op(3'b100, 32'd7, 32'd2, 1'b0);
        check("divu_const", {hi, lo}, 64'h0000_0001_0000_0003);
        run_op(3'b011, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        check("div_ovf_const", {hi, lo}, 64'h0000_0000_8000_0000);
        run_op(3'b011, 32'd7, 32'hFFFF_FFFE, 1'b0);

        // Divide by zero leaves preset HI/LO unchanged.
        move_to(3'b101, 32'h11);
        move_to(3'b110, 32'h22);
        run_op(3'b100, 32'h1234_5678, 32'd0, 1'b0);
        check("divz_const", {hi, lo}, 64'h0000_0011_0000_0022);
        run_op(3'b011, 32'h8765_4321, 32'd0, 1'b0);

        // Collision: MTLO and MULT issued while busy are ignored.
        run_op(3'b001, 32'd5, 32'd7, 1'b1);
        check("collide_lo", {32'd0, lo}, 64'd35);

        // Random ops.
        for (int i = 0; i < 6; i++) begin
            rop = 3'($urandom_range(1, 4));
            ra  = $urandom;
            rb  = (i == 3) ? 32'd0 : $urandom;
            if (i == 4) rb = 32'd3;
            run_op(rop, ra, rb, 1'b0);
        end

        // Reset mid-MULT with cnt=3: no late commit.
        move_to(3'b101, 32'h99);
        @(negedge clk);
        md_valid = 1'b1;
        md_op    = 3'b001;
        rs_data  = 32'h1234;
        rt_data  = 32'h10;
        @(negedge clk);
        md_valid = 1'b0;
        md_op    = 3'b000;
        @(negedge clk);
        @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        check("rst_mid_busy", {63'd0, busy}, 64'd0);
        check("rst_mid_hilo", {hi, lo}, 64'd0);
        check("rst_mid_stall", {63'd0, md_stall}, 64'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (12) @(negedge clk);
        check("no_late_commit", {hi, lo, 31'd0, busy}, 96'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
